// File: rtl/pond_nd_if.sv
// Data-path bundle for the pond_nd tile storage.
// Carries write data in and registered read data out.
//
// Signals:
//   data_in        : word offered to the write accessor
//   data_out       : registered word produced by the read accessor
//   data_out_valid : data_out was loaded by a read event last cycle
//
// Modports:
//   master : the producer/consumer around the tile
//   slave  : the tile itself
interface pond_nd_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;

    modport master (
        output data_in,
        input  data_out,
        input  data_out_valid
    );

    modport slave (
        input  data_in,
        output data_out,
        output data_out_valid
    );
endinterface

// File: rtl/pond_nd.sv
// Register-file tile storage with one write and one read accessor, each
// driven by an N-dimensional loop iterator, affine address and schedule.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   tile_en            : global enable, 0 freezes all state
//   flush              : synchronous restart of counters, memory kept
//   bus                : data_in / data_out / data_out_valid bundle
//   wr_* / rd_*        : per-accessor loop, address and schedule config
//   wr_done / rd_done  : accessor has completed all iterations
module pond_nd #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int NUM_DIMS   = 3,
    parameter int CNT_WIDTH  = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int DIM_WIDTH  = $clog2(NUM_DIMS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tile_en,
    input  logic                            flush,
    pond_nd_if.slave                        bus,
    input  logic [DIM_WIDTH-1:0]            wr_dimensionality,
    input  logic [NUM_DIMS*CNT_WIDTH-1:0]   wr_ranges,
    input  logic [ADDR_WIDTH-1:0]           wr_addr_start,
    input  logic [NUM_DIMS*ADDR_WIDTH-1:0]  wr_addr_strides,
    input  logic [CNT_WIDTH-1:0]            wr_sched_start,
    input  logic [NUM_DIMS*CNT_WIDTH-1:0]   wr_sched_strides,
    input  logic [DIM_WIDTH-1:0]            rd_dimensionality,
    input  logic [NUM_DIMS*CNT_WIDTH-1:0]   rd_ranges,
    input  logic [ADDR_WIDTH-1:0]           rd_addr_start,
    input  logic [NUM_DIMS*ADDR_WIDTH-1:0]  rd_addr_strides,
    input  logic [CNT_WIDTH-1:0]            rd_sched_start,
    input  logic [NUM_DIMS*CNT_WIDTH-1:0]   rd_sched_strides,
    output logic                            wr_done,
    output logic                            rd_done
);

    // Accessor index 0 is the write side, 1 is the read side.
    logic [DIM_WIDTH-1:0]           cfg_dim    [2];
    logic [NUM_DIMS*CNT_WIDTH-1:0]  cfg_rng    [2];
    logic [ADDR_WIDTH-1:0]          cfg_astart [2];
    logic [NUM_DIMS*ADDR_WIDTH-1:0] cfg_astr   [2];
    logic [CNT_WIDTH-1:0]           cfg_sstart [2];
    logic [NUM_DIMS*CNT_WIDTH-1:0]  cfg_sstr   [2];

    assign cfg_dim[0]    = wr_dimensionality;
    assign cfg_dim[1]    = rd_dimensionality;
    assign cfg_rng[0]    = wr_ranges;
    assign cfg_rng[1]    = rd_ranges;
    assign cfg_astart[0] = wr_addr_start;
    assign cfg_astart[1] = rd_addr_start;
    assign cfg_astr[0]   = wr_addr_strides;
    assign cfg_astr[1]   = rd_addr_strides;
    assign cfg_sstart[0] = wr_sched_start;
    assign cfg_sstart[1] = rd_sched_start;
    assign cfg_sstr[0]   = wr_sched_strides;
    assign cfg_sstr[1]   = rd_sched_strides;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_WIDTH-1:0]  cycle_q;

    logic [CNT_WIDTH-1:0]  cnt_q  [2][NUM_DIMS];
    logic [CNT_WIDTH-1:0]  cnt_n  [2][NUM_DIMS];
    logic [ADDR_WIDTH-1:0] aoff_q [2];
    logic [ADDR_WIDTH-1:0] aoff_n [2];
    logic [CNT_WIDTH-1:0]  soff_q [2];
    logic [CNT_WIDTH-1:0]  soff_n [2];
    logic                  done_q [2];

    logic [CNT_WIDTH-1:0]  due    [2];
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic                  fire   [2];
    logic                  last   [2];

    // The lowest active dim not yet at its range advances; every dim
    // below it was at its range and wraps to 0. No such dim means the
    // current event is the final iteration.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            logic adv;
            adv     = 1'b0;
            due[a]  = cfg_sstart[a] + soff_q[a];
            addr[a] = cfg_astart[a] + aoff_q[a];
            fire[a] = tile_en && !done_q[a] &&
                      (cfg_dim[a] != '0) && (cycle_q == due[a]);
            aoff_n[a] = aoff_q[a];
            soff_n[a] = soff_q[a];
            for (int d = 0; d < NUM_DIMS; d++) begin
                cnt_n[a][d] = cnt_q[a][d];
            end
            for (int d = 0; d < NUM_DIMS; d++) begin
                if (!adv && d < int'(cfg_dim[a])) begin
                    if (cnt_q[a][d] != cfg_rng[a][d*CNT_WIDTH +: CNT_WIDTH]) begin
                        adv         = 1'b1;
                        cnt_n[a][d] = cnt_q[a][d] + CNT_WIDTH'(1);
                        aoff_n[a]   = aoff_q[a] +
                                      cfg_astr[a][d*ADDR_WIDTH +: ADDR_WIDTH];
                        soff_n[a]   = soff_q[a] +
                                      cfg_sstr[a][d*CNT_WIDTH +: CNT_WIDTH];
                    end else begin
                        cnt_n[a][d] = '0;
                    end
                end
            end
            last[a] = !adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cycle_q            <= '0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            for (int a = 0; a < 2; a++) begin
                done_q[a] <= 1'b0;
                aoff_q[a] <= '0;
                soff_q[a] <= '0;
                for (int d = 0; d < NUM_DIMS; d++) begin
                    cnt_q[a][d] <= '0;
                end
            end
        end else begin
            // fire already folds in tile_en, so valid drops when frozen.
            bus.data_out_valid <= fire[1];
            if (fire[1]) begin
                if (fire[0] && addr[0] == addr[1]) begin
                    bus.data_out <= bus.data_in;
                end else begin
                    bus.data_out <= mem[addr[1]];
                end
            end
            if (tile_en) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
                for (int a = 0; a < 2; a++) begin
                    if (fire[a]) begin
                        if (last[a]) begin
                            done_q[a] <= 1'b1;
                            aoff_q[a] <= '0;
                            soff_q[a] <= '0;
                            for (int d = 0; d < NUM_DIMS; d++) begin
                                cnt_q[a][d] <= '0;
                            end
                        end else begin
                            aoff_q[a] <= aoff_n[a];
                            soff_q[a] <= soff_n[a];
                            for (int d = 0; d < NUM_DIMS; d++) begin
                                cnt_q[a][d] <= cnt_n[a][d];
                            end
                        end
                    end
                end
            end
        end
    end

    // Storage is never reset; writes are suppressed during rst/flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush && fire[0]) begin
            mem[addr[0]] <= bus.data_in;
        end
    end

    assign wr_done = done_q[0];
    assign rd_done = done_q[1];

endmodule

// File: tb/tb_pond_nd.sv
// Directed self-checking bench for pond_nd.
// Each task drives one scenario and compares outputs every cycle.
module tb_pond_nd;

    localparam int DW  = 16;
    localparam int DP  = 32;
    localparam int ND  = 3;
    localparam int CW  = 16;
    localparam int AW  = 5;
    localparam int DMW = 2;

    logic clk = 1'b0;
    logic rst;
    logic tile_en;
    logic flush;

    logic [DMW-1:0]   wr_dim, rd_dim;
    logic [ND*CW-1:0] wr_rng, rd_rng;
    logic [AW-1:0]    wr_ast, rd_ast;
    logic [ND*AW-1:0] wr_astr, rd_astr;
    logic [CW-1:0]    wr_sst, rd_sst;
    logic [ND*CW-1:0] wr_sstr, rd_sstr;
    logic             wr_done, rd_done;

    int checks = 0;
    int errors = 0;

    pond_nd_if #(.DATA_WIDTH(DW)) bus ();

    pond_nd #(
        .DATA_WIDTH(DW),
        .DEPTH(DP),
        .NUM_DIMS(ND),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tile_en(tile_en),
        .flush(flush),
        .bus(bus),
        .wr_dimensionality(wr_dim),
        .wr_ranges(wr_rng),
        .wr_addr_start(wr_ast),
        .wr_addr_strides(wr_astr),
        .wr_sched_start(wr_sst),
        .wr_sched_strides(wr_sstr),
        .rd_dimensionality(rd_dim),
        .rd_ranges(rd_rng),
        .rd_addr_start(rd_ast),
        .rd_addr_strides(rd_astr),
        .rd_sched_start(rd_sst),
        .rd_sched_strides(rd_sstr),
        .wr_done(wr_done),
        .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic set_wr_1d(input logic [DMW-1:0] dm, input int r0,
                             input int ast, input int sst);
        wr_dim  = dm;
        wr_rng  = {CW'(0), CW'(0), CW'(r0)};
        wr_ast  = AW'(ast);
        wr_astr = {AW'(0), AW'(0), AW'(1)};
        wr_sst  = CW'(sst);
        wr_sstr = {CW'(0), CW'(0), CW'(1)};
    endtask

    task automatic set_rd_1d(input logic [DMW-1:0] dm, input int r0,
                             input int ast, input int sst);
        rd_dim  = dm;
        rd_rng  = {CW'(0), CW'(0), CW'(r0)};
        rd_ast  = AW'(ast);
        rd_astr = {AW'(0), AW'(0), AW'(1)};
        rd_sst  = CW'(sst);
        rd_sstr = {CW'(0), CW'(0), CW'(1)};
    endtask

    task automatic test_reset();
        logic [18:0] got;
        rst = 1'b1;
        flush = 1'b0;
        tile_en = 1'b0;
        bus.data_in = '0;
        set_wr_1d(2'd0, 0, 0, 0);
        set_rd_1d(2'd0, 0, 0, 0);
        step();
        step();
        got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
        checks++;
        if (got !== 19'h0) begin
            errors++;
            $display("FAIL reset got %h want %h", got, 19'h0);
        end
        rst = 1'b0;
    endtask

    // Scenario: 1-D write at cycles 0..3, 1-D read from cycle 4.
    task automatic test_basic();
        logic        ev;
        logic [15:0] ed;
        logic [18:0] got, exp;
        ed = '0;
        set_wr_1d(2'd1, 3, 0, 0);
        set_rd_1d(2'd1, 3, 0, 4);
        tile_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.data_in = (k < 4) ? 16'(10 + k) : 16'hFFFF;
            ev = (k >= 5 && k <= 8);
            if (ev) ed = 16'(10 + k - 5);
            exp = {ev, ed, k >= 4, k >= 8};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
    endtask

    // Rerun the read after flush with writes disabled: memory persists.
    task automatic test_flush_rerun();
        logic        ev;
        logic [15:0] ed;
        logic [18:0] got, exp;
        ed = '0;
        set_wr_1d(2'd0, 3, 0, 0);
        set_rd_1d(2'd1, 3, 0, 4);
        do_flush();
        for (int k = 0; k < 10; k++) begin
            bus.data_in = 16'hAAAA;
            ev = (k >= 5 && k <= 8);
            if (ev) ed = 16'(10 + k - 5);
            exp = {ev, ed, 1'b0, k >= 8};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL flush_rerun k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
    endtask

    // tile_en low for steps 2..4 shifts every later event by 3 steps.
    task automatic test_stall();
        logic        ev, en;
        int          c;
        logic [15:0] ed;
        logic [18:0] got, exp;
        ed = '0;
        set_wr_1d(2'd1, 3, 0, 0);
        set_rd_1d(2'd1, 3, 0, 4);
        do_flush();
        for (int t = 0; t < 13; t++) begin
            en = !(t >= 2 && t <= 4);
            c = (t < 2) ? t : t - 3;
            tile_en = en;
            bus.data_in = (en && c < 4) ? 16'(20 + c) : 16'hDEAD;
            ev = (t >= 8 && t <= 11);
            if (ev) ed = 16'(20 + t - 8);
            exp = {ev, ed, t >= 7, t >= 11};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall t=%0d got %h want %h", t, got, exp);
            end
            step();
        end
        tile_en = 1'b1;
    endtask

    // Write 0x1111 then 0xBEEF to addr 5; read of addr 5 coincides
    // with the second write and must see 0xBEEF.
    task automatic test_bypass();
        logic [15:0] ed;
        logic [18:0] got, exp;
        set_wr_1d(2'd1, 1, 5, 0);
        wr_astr = '0;
        set_rd_1d(2'd1, 0, 5, 1);
        do_flush();
        for (int k = 0; k < 4; k++) begin
            bus.data_in = (k == 0) ? 16'h1111 : (k == 1) ? 16'hBEEF : 16'h0;
            ed = (k >= 2) ? 16'hBEEF : 16'h0;
            exp = {k == 2, ed, k >= 2, k >= 2};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bypass k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
    endtask

    // 2-D read, addr strides (2, -1): addresses 0,2,1,3.
    task automatic test_2d();
        logic        ev;
        logic [15:0] ed;
        logic [15:0] tbl [4];
        logic [18:0] got, exp;
        tbl = '{16'd0, 16'd2, 16'd1, 16'd3};
        ed = '0;
        set_wr_1d(2'd1, 3, 0, 0);
        rd_dim  = 2'd2;
        rd_rng  = {CW'(0), CW'(1), CW'(1)};
        rd_ast  = '0;
        rd_astr = {AW'(0), AW'(DP - 1), AW'(2)};
        rd_sst  = CW'(4);
        rd_sstr = {CW'(0), CW'(1), CW'(1)};
        do_flush();
        for (int k = 0; k < 10; k++) begin
            bus.data_in = 16'(k);
            ev = (k >= 5 && k <= 8);
            if (ev) ed = tbl[k-5];
            exp = {ev, ed, k >= 4, k >= 8};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_2d k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
    endtask

    // 3-D write, ranges (1,1,1), sched strides (1,2,3): fires at
    // cycles 0,1,3,4,7,8,10,11 into addr 8..15, done at cycle 12.
    task automatic test_3d();
        logic        ev;
        logic [15:0] ed;
        logic [15:0] tbl [8];
        logic [18:0] got, exp;
        tbl = '{16'h100, 16'h101, 16'h103, 16'h104,
                16'h107, 16'h108, 16'h10A, 16'h10B};
        ed = '0;
        wr_dim  = 2'd3;
        wr_rng  = {CW'(1), CW'(1), CW'(1)};
        wr_ast  = AW'(8);
        wr_astr = {AW'(1), AW'(1), AW'(1)};
        wr_sst  = '0;
        wr_sstr = {CW'(3), CW'(2), CW'(1)};
        set_rd_1d(2'd1, 7, 8, 12);
        do_flush();
        for (int k = 0; k < 22; k++) begin
            bus.data_in = 16'(16'h100 + k);
            ev = (k >= 13 && k <= 20);
            if (ev) ed = tbl[k-13];
            exp = {ev, ed, k >= 12, k >= 20};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL write_3d k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
    endtask

    // rst in the middle of a read burst clears outputs and done flags.
    task automatic test_reset_midrun();
        logic        ev;
        logic [15:0] ed;
        logic [18:0] got, exp;
        ed = '0;
        set_wr_1d(2'd1, 3, 0, 0);
        set_rd_1d(2'd1, 3, 0, 4);
        do_flush();
        for (int k = 0; k < 7; k++) begin
            bus.data_in = 16'(30 + k);
            ev = (k >= 5);
            if (ev) ed = 16'(30 + k - 5);
            exp = {ev, ed, k >= 4, 1'b0};
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midrun k=%0d got %h want %h", k, got, exp);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tile_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            got = {bus.data_out_valid, bus.data_out, wr_done, rd_done};
            checks++;
            if (got !== 19'h0) begin
                errors++;
                $display("FAIL midrun_rst k=%0d got %h want %h", k, got, 19'h0);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_rerun();
        test_stall();
        test_bypass();
        test_2d();
        test_3d();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pond_nd.md
Name: pond_nd

Overview:
- Parametrised successor of the single-port pond tile storage.
- One register-file memory with one write accessor (input→pond) and one read accessor (pond→output).
- Each accessor has an N-dimensional loop iterator, an affine address generator and a cycle-count schedule generator.
- Adds over the earlier pond: configurable dimension count, depth and width; registered output with a valid flag; read-during-write bypass; per-accessor done flags; synchronous flush to re-run a configuration.

Parameters:
DATA_WIDTH, 16, data word width
DEPTH, 32, memory words; power of two; ADDR_WIDTH = clog2(DEPTH)
NUM_DIMS, 3, loop dimensions per accessor (≥1)
CNT_WIDTH, 16, width of cycle counter, ranges and schedule values
DIM_WIDTH = clog2(NUM_DIMS+1), derived

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tile_en  in  1  global enable; 0 freezes all state
flush  in  1  synchronous restart of counters and accessors; memory kept
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  registered read data
data_out_valid  out  1  data_out holds a newly read word
wr_dimensionality / rd_dimensionality  in  DIM_WIDTH  active dims; 0 disables accessor
wr_ranges / rd_ranges  in  NUM_DIMS×CNT_WIDTH  per-dim extent minus 1
wr_addr_start / rd_addr_start  in  ADDR_WIDTH  base memory address
wr_addr_strides / rd_addr_strides  in  NUM_DIMS×ADDR_WIDTH  address delta applied when dim d advances
wr_sched_start / rd_sched_start  in  CNT_WIDTH  first event cycle
wr_sched_strides / rd_sched_strides  in  NUM_DIMS×CNT_WIDTH  schedule delta applied when dim d advances
wr_done / rd_done  out  1  accessor completed all iterations

Behaviour:
- rst (priority over everything, ignores tile_en) clears: cycle_count, all dim counters, addr and sched offsets, done flags, data_out, data_out_valid. Memory contents are not reset.
- flush (only when rst=0, ignores tile_en) has the same effect as rst.
- tile_en=0 with rst=flush=0:
  - All registers hold, except data_out_valid, which is forced to 0.
  - No memory write occurs.
- cycle_count increments by 1 per enabled cycle and wraps mod 2^CNT_WIDTH.
- Accessor event (fire): tile_en & ~done & dimensionality>0 & (cycle_count == sched_start + sched_offset), with the sum taken mod 2^CNT_WIDTH.
- Write fire: mem[wr_addr_start + addr_offset] <= data_in, address wrapping mod DEPTH.
- Read fire: the cycle after the fire, data_out = mem[rd addr] and data_out_valid=1. Otherwise data_out holds its value and data_out_valid=0.
- Bypass: a read fire and a write fire to the same address in the same cycle return the new data_in.
- Iterator, per accessor, on each fire:
  - d = lowest dim < dimensionality whose counter != range[d].
  - Counter[d] increments; counters[0..d-1] clear to 0.
  - addr_offset += addr_strides[d]; sched_offset += sched_strides[d].
  - If no such d exists, this was the last iteration: done <= 1, offsets and counters clear.
- Iteration count = Π(range[d]+1) over active dims.
- Dims ≥ dimensionality are ignored and their counters held at 0.
- wr_done and rd_done are registered: they assert the cycle after the final fire and stay high until rst/flush.
- done=1 blocks further fires even if cycle_count later wraps to a matching value.
- If a schedule value has already passed, the accessor stalls until cycle_count wraps to match. This is correct behaviour, not an error.
- Config inputs must be stable while tile_en=1 and not done; behaviour on mid-run config change is undefined.
- Write and read accessors are independent. Ordering hazards are the compiler's responsibility, except for the same-cycle bypass above.

Test Plan:
1. Write 1-D, ranges0=3, addr 0/stride 1, sched 0/stride 1; read 1-D same shape, sched start 4 → data_in 10,11,12,13 at cycles 0–3; data_out 10..13 with valid at cycles 5–8; wr_done high from cycle 4, rd_done high from cycle 8.
2. Read 2-D, ranges=(1,1), addr strides=(2,-1 i.e. DEPTH-1), start 0, sched strides=(1,1) after writing mem[i]=i → reads addrs 0,2,1,3; data_out 0,2,1,3.
3. Same-cycle read and write to addr 5 with data_in=0xBEEF and mem[5] previously 0x1111 → data_out=0xBEEF next cycle.
4. tile_en low for 3 cycles mid-run of scenario 1 → cycle_count frozen; events shift 3 cycles later; data_out_valid 0 during the gap; final data identical.
5. Flush after both done → cycle_count=0, done flags cleared; scenario 1 reruns with identical read results and memory intact. rst mid-run → data_out=0, valid=0, done=0.
6. wr_dimensionality=0 → no writes ever, wr_done stays 0; NUM_DIMS=3, ranges=(1,1,1) → exactly 8 fires, then wr_done.
